// File: rtl/hyst_writer_pkg.sv
// Shared edge-detector constants and the result-column type exchanged
// between the hysteresis stage and the output writer.
package hyst_writer_pkg;

    localparam int PIX_W             = 8;
    localparam int ROWS_PER_BLK      = 10;
    localparam int IMG_WIDTH_DEFAULT = 256;

    // Element 0 is the top row of the 10-row block.
    typedef logic [ROWS_PER_BLK-1:0][PIX_W-1:0] column_t;

endpackage : hyst_writer_pkg

// File: rtl/hyst_writer_flex_counter.sv
// Generic up-counter with a programmable rollover value; wraps to 0 after
// reaching rollover_val while enabled.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        // NOTE: assign the default first so every path drives count_d; a missing branch would infer a latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule : flex_counter

// File: rtl/hyst_writer.sv
// Captures hysteresis result columns into a two-entry ping-pong buffer and
// writes them pixel by pixel into a row-major output memory.
module hyst_writer
    import hyst_writer_pkg::*;
#(
    parameter int          IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int          NUM_BLOCKS = 24,
    parameter int          ADDR_BITS  = 18,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 hyst_final,
    input  column_t              hyst_out,
    input  logic                 mem_busy,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [PIX_W-1:0]     mem_data,
    output logic                 writer_busy,
    output logic                 overrun,
    output logic                 frame_done
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [3:0]       PIX_LAST = 4'(ROWS_PER_BLK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ADVANCE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       valid_q, valid_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             overrun_q, overrun_d;
    logic             prev_q, prev_d;
    column_t          entry_q [2];
    column_t          entry_d [2];

    logic       cap_evt;
    logic       col_done;
    logic       pix_en;
    logic       pix_last;
    logic [3:0] pix;

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_pix_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (1'b0),
        .count_enable  (pix_en),
        .rollover_val  (PIX_LAST),
        .count_out     (pix),
        .rollover_flag (pix_last)
    );

    // ------------------------------------------------------------------
    // Capture side: rising edge of hyst_final loads the entry at wr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        cap_evt   = hyst_final & ~prev_q;
        prev_d    = hyst_final;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        entry_d   = entry_q;

        if (col_done) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ~rd_ptr_q;
        end

        // A full buffer still accepts the column if the entry being drained
        // retires its last pixel in this same cycle.
        if (cap_evt) begin
            if (!valid_q[wr_ptr_q] || (col_done && (wr_ptr_q == rd_ptr_q))) begin
                entry_d[wr_ptr_q] = hyst_out;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = ~wr_ptr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain side: write ten pixels, then step the column/block position.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        blk_d      = blk_q;
        pix_en     = 1'b0;
        col_done   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_q[rd_ptr_q]) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                mem_write = 1'b1;
                mem_data  = entry_q[rd_ptr_q][pix];
                mem_addr  = ADDR_BITS'(BASE_ADDR
                          + ((32'(blk_q) * 32'(ROWS_PER_BLK) + 32'(pix)) * 32'(IMG_WIDTH)
                          + 32'(col_q)));
                if (!mem_busy) begin
                    pix_en = 1'b1;
                    if (pix_last) begin
                        col_done = 1'b1;
                        state_d  = S_ADVANCE;
                    end
                end
            end

            S_ADVANCE: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (blk_q == BLK_LAST) begin
                        blk_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                // rd_ptr_q already points at the next entry here.
                state_d = valid_q[rd_ptr_q] ? S_WRITE : S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            col_q     <= '0;
            blk_q     <= '0;
            overrun_q <= 1'b0;
            prev_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            col_q     <= col_d;
            blk_q     <= blk_d;
            overrun_q <= overrun_d;
            prev_q    <= prev_d;
        end
    end

    // NOTE: buffer payload is deliberately not reset; the valid bits gate every read of it.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign writer_busy = valid_q[0] & valid_q[1];
    assign overrun     = overrun_q;

endmodule : hyst_writer

// File: doc/hyst_writer.md
HYST_WRITER -- requirements
Module: hyst_writer

Interface
REQ-001 IMG_WIDTH, 256, output row length in pixels (columns per row-block).
REQ-002 NUM_BLOCKS, 24, number of 10-row blocks per frame.
REQ-003 ADDR_BITS, 18, output-memory byte-address width.
REQ-004 BASE_ADDR, 0, byte address of output pixel (row 0, col 0).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 n_rst  input  1  reset, asynchronous, active-low.
REQ-007 hyst_final  input  1  hysteresis-stage status; a 0->1 transition marks a fresh result column.
REQ-008 hyst_out  input  10x8  result column; element 0 = top row of block.
REQ-009 mem_busy  input  1  memory cannot accept a write this cycle.
REQ-010 mem_write  output  1  write request.
REQ-011 mem_addr  output  ADDR_BITS  write byte address.
REQ-012 mem_data  output  8  write pixel.
REQ-013 writer_busy  output  1  both buffer entries occupied; upstream SHALL NOT move anchor.
REQ-014 overrun  output  1  sticky; a result column was dropped.
REQ-015 frame_done  output  1  one-cycle pulse after the final column of a frame is written.

Function
REQ-016 Capture event SHALL be hyst_final=1 while a registered copy of it (prev) =0.
REQ-017 Two-entry ping-pong buffer (80-bit data + valid each); on a capture event, hyst_out SHALL be stored in the entry at wr_ptr, valid set, wr_ptr toggled.
REQ-018 Capture with both entries valid SHALL drop data, set overrun=1, leave pointers unchanged; exception: if the entry at rd_ptr completes its last write that cycle, capture SHALL succeed into it.
REQ-019 FSM states IDLE, WRITE, ADVANCE; IDLE->WRITE when entry[rd_ptr] valid.
REQ-020 In WRITE: mem_write=1, mem_data=entry[rd_ptr][pix], mem_addr=BASE_ADDR+((blk*10+pix)*IMG_WIDTH+col), truncated to ADDR_BITS.
REQ-021 pix SHALL advance only on cycles with mem_write=1 and mem_busy=0; mem_addr/mem_data SHALL hold while mem_busy=1.
REQ-022 After pix 9 is accepted: clear entry valid, toggle rd_ptr, pix=0, go to ADVANCE.
REQ-023 ADVANCE: col+1; at col=IMG_WIDTH-1 col wraps to 0 and blk+1; at blk=NUM_BLOCKS-1 with col wrap, blk=0 and frame_done=1 for that cycle.
REQ-024 ADVANCE->WRITE if the new entry[rd_ptr] is valid, else IDLE.
REQ-025 Outside WRITE, mem_write, mem_addr, mem_data SHALL be 0.
REQ-026 Latency: first mem_write asserts two cycles after the cycle in which the capture event is detected; a column takes 11 cycles minimum with mem_busy=0 (10 writes + ADVANCE).
REQ-027 writer_busy SHALL equal (valid0 & valid1), derived from registers only.

Reset
REQ-028 On n_rst=0: state IDLE, both valid bits 0, wr_ptr=rd_ptr=0, pix=col=blk=0, all outputs 0, overrun 0.
REQ-029 prev SHALL reset to 1, so hyst_final high from the upstream idle state does not count as a capture event.
REQ-030 Reset mid-column SHALL abandon that column; the next capture writes at col 0, blk 0.
REQ-031 overrun SHALL clear only by reset.

Structure
REQ-032 The shared edge-detector package SHALL hold the pixel width (8), rows per block (10) and the IMG_WIDTH default; the FSM enum stays local.
REQ-033 pix SHALL be an instance of the existing flex_counter (4 bits, rollover 9); col/blk are local registers.

Verification
REQ-034 Reset, hyst_final held 1, no 0->1 transition -> mem_write never asserts; all outputs 0.
REQ-035 hyst_final 0->1 with hyst_out[i]=i+1, mem_busy=0 -> 10 consecutive writes, addr 0,256,...,2304, data 1..10.
REQ-036 mem_busy=1 for 3 cycles while pix=4 -> addr 1024/data 5 held 4 cycles; no skipped or duplicated pixel.
REQ-037 mem_busy held 1, three capture events -> writer_busy=1 after the second, overrun=1 after the third; after release, only the first two columns are written (col 0, col 1).
REQ-038 IMG_WIDTH=4, NUM_BLOCKS=2, 8 columns -> 5th column pix 0 at addr 40; frame_done pulses once after column 8; 9th column at addr 0.
REQ-039 n_rst pulsed low after 5 writes of a column -> outputs 0 asynchronously; next capture writes pix 0 at addr BASE_ADDR.
